// File: rtl/pll_mon_pkg.sv
`timescale 1ns/1ps
// Shared FSM state type and parameter defaults for the PLL clock-frequency monitor.
package pll_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATE   = 2'd1,
    ST_REPORT = 2'd2
  } mon_state_t;

  localparam int DEF_GATE_CYCLES  = 100000;
  localparam int DEF_CNT_W        = 24;
  localparam int DEF_TOL          = 20;
  localparam int DEF_GOOD_WINDOWS = 4;

endpackage

// File: rtl/sync_edge_det.sv
`timescale 1ns/1ps
// Two-flop synchronizer for an asynchronous clock plus a rising-edge pulse.
// Latency: 2 cycles to the synchronized value; rise is a one-cycle pulse.
module sync_edge_det (
  input  logic clk_in,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  // sh[1:0] form the synchronizer, sh[2] holds the previous synchronized value
  logic [2:0] sh;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) sh <= '0;
    else        sh <= {sh[1:0], async_in};
  end

  assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/clk_freq_monitor.sv
`timescale 1ns/1ps
// Counts meas_clk rising edges over a fixed gate window of clk_in cycles, checks the
// count against a tolerance band and raises freq_ok after enough consecutive good windows.
module clk_freq_monitor
  import pll_mon_pkg::*;
#(
  parameter int GATE_CYCLES  = DEF_GATE_CYCLES,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int TOL          = DEF_TOL,
  parameter int GOOD_WINDOWS = DEF_GOOD_WINDOWS
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             meas_clk,
  input  logic             enable,
  input  logic [CNT_W-1:0] expected_count,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic             in_range,
  output logic             freq_ok
);

  localparam int GW  = $clog2(GATE_CYCLES + 1);
  localparam int GDW = $clog2(GOOD_WINDOWS + 1);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W:0]   TOL_V     = (CNT_W+1)'(TOL);
  localparam logic [GDW-1:0]   GOOD_V    = GDW'(GOOD_WINDOWS);

  mon_state_t       state;
  logic             edge_rise;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] exp_lat;
  logic [GDW-1:0]   good_cnt;

  logic [CNT_W-1:0] edge_next;
  logic [CNT_W:0]   diff;
  logic [CNT_W:0]   abs_dev;
  logic             window_ok;
  logic [GDW-1:0]   good_inc;

  sync_edge_det u_sync (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .async_in (meas_clk),
    .rise     (edge_rise)
  );

  // edge_next includes the current cycle so the last gate cycle's edge is reported
  always_comb begin
    edge_next = (edge_rise && (edge_cnt != CNT_MAX)) ? edge_cnt + 1'b1 : edge_cnt;
    diff      = {1'b0, edge_next} - {1'b0, exp_lat};
    abs_dev   = diff[CNT_W] ? (~diff + (CNT_W+1)'(1)) : diff;
    window_ok = (abs_dev <= TOL_V);
    good_inc  = (good_cnt == GOOD_V) ? good_cnt : good_cnt + 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      exp_lat    <= '0;
      good_cnt   <= '0;
      meas_count <= '0;
      meas_valid <= 1'b0;
      in_range   <= 1'b0;
      freq_ok    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state    <= ST_GATE;
            edge_cnt <= '0;
            gate_cnt <= '0;
            exp_lat  <= expected_count;
          end
        end
        ST_GATE: begin
          if (!enable) begin
            state    <= ST_IDLE;
            good_cnt <= '0;
            freq_ok  <= 1'b0;
          end else begin
            edge_cnt <= edge_next;
            gate_cnt <= gate_cnt + 1'b1;
            if (gate_cnt == GATE_LAST) begin
              state      <= ST_REPORT;
              meas_valid <= 1'b1;
              meas_count <= edge_next;
              in_range   <= window_ok;
            end
          end
        end
        ST_REPORT: begin
          if (in_range) begin
            good_cnt <= good_inc;
            freq_ok  <= (good_inc == GOOD_V);
          end else begin
            good_cnt <= '0;
            freq_ok  <= 1'b0;
          end
          // back-to-back windows: the next gate starts right after the report cycle
          if (enable) begin
            state    <= ST_GATE;
            edge_cnt <= '0;
            gate_cnt <= '0;
            exp_lat  <= expected_count;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
